perf_counter_array: RTL and testbench

Parametrised bank of event counters for the pipelined RV32I core, replacing the fixed-function performance counter. Each of `NUM_CNT` counters is software-configured to count one of `NUM_EVT` single-cycle event strobes (cache hits/accesses, branches, mispredicts, stalls, ...). The counters support wrap or saturate mode, sticky overflow flags and a synchronous snapshot bank. Counter values are read combinationally by index from the EXE stage, as the CSR-style read path does today.

---
 rtl/perf_counter_array.sv | 128 ++++++++++++
 tb/tb_perf_counter_array.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_array.sv
// Event counter bank: NUM_CNT counters, each counting one selectable event strobe (wrap/saturate, sticky ovf).
// Latency: event at cycle N visible on rd_data_o at N+1; read path is combinational from registers.
// Backpressure: none, all inputs are single-cycle strobes; PERF_SNAPSHOT_EN builds the shadow bank.
module perf_counter_array #(
    parameter int NUM_CNT   = 8,
    parameter int CNT_WIDTH = 32,
    parameter int NUM_EVT   = 16,
    localparam int IDX_W    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
    localparam int EVT_W    = $clog2(NUM_EVT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_EVT-1:0]   evt_i,
    input  logic                 freeze_i,
    input  logic                 cfg_we_i,
    input  logic [IDX_W-1:0]     cfg_idx_i,
    input  logic [EVT_W-1:0]     cfg_evt_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_sat_i,
    input  logic [NUM_CNT-1:0]   clr_i,
    input  logic                 snap_i,
    input  logic [4:0]           rd_idx_i,
    input  logic                 rd_shadow_i,
    output logic [CNT_WIDTH-1:0] rd_data_o,
    output logic [NUM_CNT-1:0]   ovf_o,
    output logic                 irq_o
);

    logic [CNT_WIDTH-1:0] val_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] val_d [NUM_CNT];
    logic [EVT_W-1:0]     sel_q [NUM_CNT];
    logic [EVT_W-1:0]     sel_d [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_q, ovf_d;
    logic [NUM_CNT-1:0]   en_q, en_d;
    logic [NUM_CNT-1:0]   sat_q, sat_d;
    logic [NUM_CNT-1:0]   inc;
    logic                 cfg_ok;

    // Out-of-range event selects are dropped entirely; out-of-range indices match no counter.
    assign cfg_ok = cfg_we_i && (32'(cfg_evt_i) < 32'(NUM_EVT));

    always_comb begin
        val_d = val_q;
        sel_d = sel_q;
        ovf_d = ovf_q;
        en_d  = en_q;
        sat_d = sat_q;
        inc   = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            // Increment decision uses the pre-write config, so a same-cycle write applies from N+1.
            inc[i] = en_q[i] & ~freeze_i & evt_i[sel_q[i]];
            if (clr_i[i]) begin
                val_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (inc[i]) begin
                if (&val_q[i]) begin
                    ovf_d[i] = 1'b1;
                    if (!sat_q[i]) val_d[i] = '0;
                end else begin
                    val_d[i] = val_q[i] + 1'b1;
                end
            end
            if (cfg_ok && (cfg_idx_i == IDX_W'(i))) begin
                sel_d[i] = cfg_evt_i;
                en_d[i]  = cfg_en_i;
                sat_d[i] = cfg_sat_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                val_q[i] <= '0;
                sel_q[i] <= EVT_W'(i % NUM_EVT);
            end
            ovf_q <= '0;
            en_q  <= '0;
            sat_q <= '0;
        end else begin
            val_q <= val_d;
            sel_q <= sel_d;
            ovf_q <= ovf_d;
            en_q  <= en_d;
            sat_q <= sat_d;
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_WIDTH-1:0] shd_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] shd_d [NUM_CNT];

    // Shadow takes pre-edge live values, so same-cycle increments/clears are not captured.
    always_comb begin
        shd_d = shd_q;
        if (snap_i) shd_d = val_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) shd_q[i] <= '0;
        end else begin
            shd_q <= shd_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_idx_i == 5'(i)) rd_data_o = rd_shadow_i ? shd_q[i] : val_q[i];
        end
    end
`else
    logic unused_snap;
    assign unused_snap = snap_i ^ rd_shadow_i;

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_idx_i == 5'(i)) rd_data_o = val_q[i];
        end
    end
`endif

    assign ovf_o = ovf_q;
    assign irq_o = |ovf_q;

endmodule

// File: tb/tb_perf_counter_array.sv
// Directed bench for perf_counter_array (6 counters x 8 bits, 12 events) with hand-computed expectations.
module tb_perf_counter_array;

    localparam int NC = 6;
    localparam int CW = 8;
    localparam int NE = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NE-1:0] evt_i;
    logic          freeze_i;
    logic          cfg_we_i;
    logic [2:0]    cfg_idx_i;
    logic [3:0]    cfg_evt_i;
    logic          cfg_en_i;
    logic          cfg_sat_i;
    logic [NC-1:0] clr_i;
    logic          snap_i;
    logic [4:0]    rd_idx_i;
    logic          rd_shadow_i;
    logic [CW-1:0] rd_data_o;
    logic [NC-1:0] ovf_o;
    logic          irq_o;

    int total = 0;
    int bad   = 0;

    perf_counter_array #(.NUM_CNT(NC), .CNT_WIDTH(CW), .NUM_EVT(NE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .evt_i      (evt_i),
        .freeze_i   (freeze_i),
        .cfg_we_i   (cfg_we_i),
        .cfg_idx_i  (cfg_idx_i),
        .cfg_evt_i  (cfg_evt_i),
        .cfg_en_i   (cfg_en_i),
        .cfg_sat_i  (cfg_sat_i),
        .clr_i      (clr_i),
        .snap_i     (snap_i),
        .rd_idx_i   (rd_idx_i),
        .rd_shadow_i(rd_shadow_i),
        .rd_data_o  (rd_data_o),
        .ovf_o      (ovf_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input int idx, input logic shadow, input int exp);
        rd_idx_i    = 5'(idx);
        rd_shadow_i = shadow;
        #1;
        chk(tag, 64'(rd_data_o), 64'(exp));
        rd_shadow_i = 1'b0;
    endtask

    task automatic cfg(input int idx, input int evt, input logic en, input logic sat);
        cfg_we_i  = 1'b1;
        cfg_idx_i = 3'(idx);
        cfg_evt_i = 4'(evt);
        cfg_en_i  = en;
        cfg_sat_i = sat;
        cyc();
        cfg_we_i  = 1'b0;
    endtask

    task automatic pulse(input int e, input int n);
        evt_i = NE'(1) << e;
        repeat (n) cyc();
        evt_i = '0;
    endtask

    initial begin
        rst_n = 1'b0; evt_i = '0; freeze_i = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0;
        cfg_evt_i = '0; cfg_en_i = 1'b0; cfg_sat_i = 1'b0; clr_i = '0; snap_i = 1'b0;
        rd_idx_i = '0; rd_shadow_i = 1'b0;
        #1;
        for (int i = 0; i < NC; i++) rd_chk($sformatf("rst_val%0d", i), i, 1'b0, 0);
        chk("rst_irq", 64'(irq_o), 64'd0);
        chk("rst_ovf", 64'(ovf_o), 64'd0);
        rd_chk("rd_idx31", 31, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // Counter 2 on event 5, 10 strobes with 3 frozen.
        cfg(2, 5, 1'b1, 1'b0);
        evt_i = NE'(1) << 5;
        for (int k = 0; k < 10; k++) begin
            freeze_i = (k >= 3 && k < 6);
            cyc();
        end
        evt_i = '0; freeze_i = 1'b0;
        rd_chk("freeze_cnt", 2, 1'b0, 7);
        rd_chk("disabled_cnt5", 5, 1'b0, 0);

        // Wrap mode on counter 0.
        cfg(0, 0, 1'b1, 1'b0);
        pulse(0, 255);
        rd_chk("wrap_pre", 0, 1'b0, 255);
        chk("wrap_pre_ovf", 64'(ovf_o), 64'd0);
        pulse(0, 1);
        rd_chk("wrap_val", 0, 1'b0, 0);
        chk("wrap_ovf", 64'(ovf_o), 64'h1);
        chk("wrap_irq", 64'(irq_o), 64'd1);
        pulse(0, 3);
        chk("ovf_sticky", 64'(ovf_o), 64'h1);
        clr_i = 6'b000001;
        cyc();
        clr_i = '0;
        rd_chk("clr_val", 0, 1'b0, 0);
        chk("clr_ovf", 64'(ovf_o), 64'd0);
        chk("clr_irq", 64'(irq_o), 64'd0);

        // Saturate mode on counter 0.
        cfg(0, 0, 1'b1, 1'b1);
        pulse(0, 300);
        rd_chk("sat_val", 0, 1'b0, 255);
        chk("sat_ovf", 64'(ovf_o), 64'h1);
        clr_i = 6'b000001;
        cyc();
        clr_i = '0;

        // Clear beats a same-cycle increment on counter 1.
        cfg(1, 1, 1'b1, 1'b0);
        pulse(1, 4);
        rd_chk("c1_pre", 1, 1'b0, 4);
        clr_i = 6'b000010;
        evt_i = NE'(1) << 1;
        cyc();
        clr_i = '0; evt_i = '0;
        rd_chk("clr_prio", 1, 1'b0, 0);

        // Same-cycle reselect: old event counts this cycle, new one afterwards.
        evt_i = NE'(1) << 1;
        cfg(1, 3, 1'b1, 1'b0);
        rd_chk("cfg_old_evt", 1, 1'b0, 1);
        cyc();
        evt_i = '0;
        rd_chk("old_evt_gone", 1, 1'b0, 1);
        pulse(3, 1);
        rd_chk("new_evt", 1, 1'b0, 2);

        // Out-of-range event select is ignored: counter 1 stays enabled on event 3.
        cfg(1, 13, 1'b0, 1'b0);
        pulse(3, 1);
        rd_chk("bad_evt_ignored", 1, 1'b0, 3);
        cfg(6, 3, 1'b1, 1'b0);
        rd_chk("bad_idx_c1", 1, 1'b0, 3);
        rd_chk("rd_idx6", 6, 1'b0, 0);

        // Snapshot at 20 with a concurrent increment.
        cfg(3, 7, 1'b1, 1'b0);
        pulse(7, 20);
        rd_chk("snap_pre", 3, 1'b0, 20);
        evt_i = NE'(1) << 7;
        snap_i = 1'b1;
        cyc();
        evt_i = '0; snap_i = 1'b0;
        rd_chk("snap_live", 3, 1'b0, 21);
`ifdef PERF_SNAPSHOT_EN
        rd_chk("snap_shadow", 3, 1'b1, 20);
`else
        rd_chk("snap_shadow", 3, 1'b1, 21);
`endif

        // Async reset mid-count, counters stay disabled afterwards.
        evt_i = NE'(1) << 7;
        #2 rst_n = 1'b0;
        #1;
        rd_chk("async_rst", 3, 1'b0, 0);
        rd_chk("async_rst_shd", 3, 1'b1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) cyc();
        evt_i = '0;
        rd_chk("post_rst_disabled", 3, 1'b0, 0);
        chk("post_rst_irq", 64'(irq_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
